// File: rtl/matrix_scan_bcm.sv
// HUB75 panel scanner: shifts colour bit-planes into the panel chain and shows them with binary-coded OE timing.
// Optional SCAN_DIMMING_EN adds dim[1:0], which shortens OE-active time inside an unchanged display window.
module matrix_scan_bcm #(
  parameter int unsigned COLUMNS   = 64,
  parameter int unsigned ROW_BITS  = 4,
  parameter int unsigned BIT_DEPTH = 6,
  parameter int unsigned BASE_TIME = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef SCAN_DIMMING_EN
  input  logic [1:0]          dim,
`endif
  output logic [5:0]          column_address,
  input  logic [5:0]          red,
  input  logic [5:0]          green,
  input  logic [5:0]          blue,
  output logic [2:0]          panel_rgb1,
  output logic [2:0]          panel_rgb2,
  output logic                panel_clk,
  output logic                panel_latch,
  output logic                panel_oe_n,
  output logic [ROW_BITS-1:0] row_address,
  output logic                frame_start
);

  localparam int unsigned COL_W   = 6;
  localparam int unsigned PLANE_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2((BASE_TIME << (BIT_DEPTH - 1)) + 1);

  typedef enum logic [1:0] {
    S_SHIFT   = 2'd0,
    S_LATCH   = 2'd1,
    S_DISPLAY = 2'd2,
    S_BLANK   = 2'd3
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic                r_phase,  w_phase_nxt;
  logic [COL_W-1:0]    r_column, w_column_nxt;
  logic [PLANE_W-1:0]  r_plane,  w_plane_nxt;
  logic [ROW_BITS-1:0] r_row,    w_row_nxt;
  logic [CNT_W-1:0]    r_count,  w_count_nxt;
  logic [CNT_W-1:0]    r_on_cnt, w_on_cnt_nxt;

  logic [2:0]          r_rgb,    w_rgb_nxt;
  logic                r_pclk,   w_pclk_nxt;
  logic                r_latch,  w_latch_nxt;
  logic                r_oe_n,   w_oe_n_nxt;
  logic [ROW_BITS-1:0] r_row_addr;
  logic                r_frame_start, w_frame_start_nxt;

  logic [CNT_W-1:0]    w_window;
  logic [CNT_W-1:0]    w_on_time;

  assign w_window = CNT_W'(BASE_TIME << r_plane);

`ifdef SCAN_DIMMING_EN
  assign w_on_time = w_window >> dim;
`else
  assign w_on_time = w_window;
`endif

  // Panel outputs are registered from the state being left, so they lag the scan state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_SHIFT;
      r_phase       <= 1'b0;
      r_column      <= '0;
      r_plane       <= '0;
      r_row         <= '0;
      r_count       <= '0;
      r_on_cnt      <= '0;
      r_rgb         <= '0;
      r_pclk        <= 1'b0;
      r_latch       <= 1'b0;
      r_oe_n        <= 1'b1;
      r_row_addr    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_column      <= w_column_nxt;
      r_plane       <= w_plane_nxt;
      r_row         <= w_row_nxt;
      r_count       <= w_count_nxt;
      r_on_cnt      <= w_on_cnt_nxt;
      r_rgb         <= w_rgb_nxt;
      r_pclk        <= w_pclk_nxt;
      r_latch       <= w_latch_nxt;
      r_oe_n        <= w_oe_n_nxt;
      r_row_addr    <= r_row;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_column_nxt      = r_column;
    w_plane_nxt       = r_plane;
    w_row_nxt         = r_row;
    w_count_nxt       = r_count;
    w_on_cnt_nxt      = r_on_cnt;
    w_rgb_nxt         = r_rgb;
    w_pclk_nxt        = 1'b0;
    w_latch_nxt       = 1'b0;
    w_oe_n_nxt        = 1'b1;
    w_frame_start_nxt = 1'b0;

    case (r_state)
      S_SHIFT: begin
        w_pclk_nxt = r_phase;
        if (!r_phase) begin
          w_rgb_nxt         = {blue[r_plane], green[r_plane], red[r_plane]};
          w_frame_start_nxt = (r_column == '0) && (r_plane == '0) && (r_row == '0);
          w_phase_nxt       = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (r_column == COL_W'(COLUMNS - 1)) begin
            w_column_nxt = '0;
            w_state_nxt  = S_LATCH;
          end else begin
            w_column_nxt = r_column + COL_W'(1);
          end
        end
      end

      S_LATCH: begin
        w_latch_nxt  = 1'b1;
        w_count_nxt  = w_window;
        w_on_cnt_nxt = w_on_time;
        w_state_nxt  = S_DISPLAY;
      end

      // OE is active for the first r_on_cnt cycles of the full plane window.
      S_DISPLAY: begin
        w_oe_n_nxt  = (r_on_cnt == '0);
        w_count_nxt = r_count - CNT_W'(1);
        if (r_on_cnt != '0) begin
          w_on_cnt_nxt = r_on_cnt - CNT_W'(1);
        end
        if (r_count <= CNT_W'(1)) begin
          w_state_nxt = S_BLANK;
        end
      end

      S_BLANK: begin
        if (r_plane == PLANE_W'(BIT_DEPTH - 1)) begin
          w_plane_nxt = '0;
          w_row_nxt   = r_row + ROW_BITS'(1);
        end else begin
          w_plane_nxt = r_plane + PLANE_W'(1);
        end
        w_state_nxt = S_SHIFT;
      end

      default: w_state_nxt = S_SHIFT;
    endcase
  end

  assign column_address = r_column;
  assign panel_rgb1     = r_rgb;
  assign panel_rgb2     = r_rgb;
  assign panel_clk      = r_pclk;
  assign panel_latch    = r_latch;
  assign panel_oe_n     = r_oe_n;
  assign row_address    = r_row_addr;
  assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Self-checking bench for matrix_scan_bcm: every output cycle is compared with a frame-position model.
module tb_matrix_scan_bcm;

  localparam int COLUMNS   = 64;
  localparam int ROW_BITS  = 4;
  localparam int BIT_DEPTH = 6;
  localparam int BASE_TIME = 8;
  localparam int SHIFT_LEN = 2 * COLUMNS;
  localparam int ROW_LEN   = BIT_DEPTH * (SHIFT_LEN + 2) + BASE_TIME * ((1 << BIT_DEPTH) - 1);
  localparam int FRAME     = ROW_LEN << ROW_BITS;

  logic                clk = 1'b0;
  logic                reset;
  logic [5:0]          column_address;
  logic [5:0]          red, green, blue;
  logic [2:0]          panel_rgb1, panel_rgb2;
  logic                panel_clk, panel_latch, panel_oe_n;
  logic [ROW_BITS-1:0] row_address;
  logic                frame_start;
`ifdef SCAN_DIMMING_EN
  logic [1:0]          dim;
`endif

  int          n_checks;
  int          n_fail;
  int          mode;
  int          dim_v;
  int          n_rise;
  int          n_oe_low;
  logic        prev_clk;
  logic [17:0] palette [64];

  always #5 clk = ~clk;

  matrix_scan_bcm dut (
    .clk            (clk),
    .reset          (reset),
`ifdef SCAN_DIMMING_EN
    .dim            (dim),
`endif
    .column_address (column_address),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .panel_rgb1     (panel_rgb1),
    .panel_rgb2     (panel_rgb2),
    .panel_clk      (panel_clk),
    .panel_latch    (panel_latch),
    .panel_oe_n     (panel_oe_n),
    .row_address    (row_address),
    .frame_start    (frame_start)
  );

  // Colour source: combinational lookup of the requested column.
  always_comb begin
    case (mode)
      1: begin
        red = 6'b000001; green = 6'b000000; blue = 6'b100000;
      end
      2: begin
        red = column_address; green = ~column_address; blue = 6'b000000;
      end
      default: {blue, green, red} = palette[column_address];
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_bits(input int col, input int b);
    logic [5:0]  r, g, bl;
    logic [17:0] p;
    case (mode)
      1: begin r = 6'd1; g = 6'd0; bl = 6'd32; end
      2: begin r = 6'(col); g = ~6'(col); bl = 6'd0; end
      default: begin p = palette[col]; r = p[5:0]; g = p[11:6]; bl = p[17:12]; end
    endcase
    return {bl[b], g[b], r[b]};
  endfunction

  function automatic int plane_len(input int b);
    return SHIFT_LEN + 2 + (BASE_TIME << b);
  endfunction

  // Position of output cycle t within the frame: row, plane and offset inside the plane.
  task automatic decode(input int t, output int row, output int b, output int o);
    int f;
    f   = t % FRAME;
    row = f / ROW_LEN;
    o   = f % ROW_LEN;
    b   = 0;
    while (o >= plane_len(b)) begin
      o -= plane_len(b);
      b++;
    end
  endtask

  task automatic check_cycle(input int t);
    int row, b, o, on, row2, b2, o2;
    logic e_clk, e_latch, e_oe_n, e_fs;
    logic [2:0] e_rgb;
    decode(t, row, b, o);
    on      = (BASE_TIME << b) >> dim_v;
    e_clk   = (o < SHIFT_LEN) && (o % 2 == 1);
    e_latch = (o == SHIFT_LEN);
    e_oe_n  = !((o > SHIFT_LEN) && (o <= SHIFT_LEN + on));
    e_fs    = (row == 0) && (b == 0) && (o == 0);
    check_eq("panel_clk",   32'(panel_clk),   32'(e_clk));
    check_eq("panel_latch", 32'(panel_latch), 32'(e_latch));
    check_eq("panel_oe_n",  32'(panel_oe_n),  32'(e_oe_n));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("row_address", 32'(row_address), 32'(row));
    if (o < SHIFT_LEN) begin
      e_rgb = exp_bits(o / 2, b);
      check_eq("panel_rgb1", 32'(panel_rgb1), 32'(e_rgb));
      check_eq("panel_rgb2", 32'(panel_rgb2), 32'(e_rgb));
    end
    decode(t + 1, row2, b2, o2);
    check_eq("column_address", 32'(column_address), (o2 < SHIFT_LEN) ? 32'(o2 / 2) : 32'd0);
    if (panel_clk && !prev_clk) n_rise++;
    if (!panel_oe_n) n_oe_low++;
    prev_clk = panel_clk;
  endtask

  task automatic run(input int n);
    n_rise   = 0;
    n_oe_low = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_cycle(i);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_clk"},   32'(panel_clk),      32'd0);
    check_eq({tag, "_latch"}, 32'(panel_latch),    32'd0);
    check_eq({tag, "_oe_n"},  32'(panel_oe_n),     32'd1);
    check_eq({tag, "_rgb1"},  32'(panel_rgb1),     32'd0);
    check_eq({tag, "_rgb2"},  32'(panel_rgb2),     32'd0);
    check_eq({tag, "_row"},   32'(row_address),    32'd0);
    check_eq({tag, "_fs"},    32'(frame_start),    32'd0);
    check_eq({tag, "_col"},   32'(column_address), 32'd0);
  endtask

  task automatic set_dim(input int d);
`ifdef SCAN_DIMMING_EN
    dim   = 2'(d);
    dim_v = d;
`else
    dim_v = 0 * d;
`endif
  endtask

  function automatic int row_oe_low();
    int s;
    s = 0;
    for (int b = 0; b < BIT_DEPTH; b++) s += (BASE_TIME << b) >> dim_v;
    return s;
  endfunction

  initial begin
    int tgt;
    n_checks = 0;
    n_fail   = 0;
    mode     = 0;
    reset    = 1'b1;
    set_dim(2);
    for (int c = 0; c < 64; c++) palette[c] = 18'($urandom);

    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset_values("rst_hold");
    end

    // Random palette across a full frame plus the start of the next one.
    reset = 1'b0;
    run(FRAME + 1300);

    // Constant colours: plane 0 -> 001, plane 5 -> 100, others 000.
    reset = 1'b1;
    mode  = 1;
    @(posedge clk);
    #1;
    check_reset_values("rst_const");
    reset = 1'b0;
    run(ROW_LEN);
    check_eq("row_clk_rises", 32'(n_rise), 32'(BIT_DEPTH * COLUMNS));
    check_eq("row_oe_low", 32'(n_oe_low), 32'(row_oe_low()));

    // red follows column_address.
    reset = 1'b1;
    mode  = 2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(ROW_LEN);
    check_eq("sweep_clk_rises", 32'(n_rise), 32'(BIT_DEPTH * COLUMNS));

    // Reset in the middle of row 7, plane 3 display.
    reset = 1'b1;
    mode  = 0;
    set_dim($urandom_range(0, 3));
    for (int c = 0; c < 64; c++) palette[c] = 18'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tgt = 7 * ROW_LEN + plane_len(0) + plane_len(1) + plane_len(2) + SHIFT_LEN + 1;
    run(tgt + 1);
    check_eq("mid_pre_row", 32'(row_address), 32'd7);
    check_eq("mid_pre_latch", 32'(panel_latch), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("mid_rst");
    reset = 1'b0;
    run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
